// File: rtl/pmod_reader_pkg.sv
// Purpose: shared constants and sizing helpers for the PMOD input reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pmod_reader_pkg;

    localparam int DEF_CLK_HZ    = 100_000_000;
    localparam int DEF_TICK_HZ   = 10_000;
    localparam int DEF_DEB_TICKS = 8;
    localparam int DEF_WIDTH     = 8;

    // Clock cycles per debounce tick for the default configuration
    localparam int DEF_TICK_DIV  = DEF_CLK_HZ / DEF_TICK_HZ;

    // Cycles per debounce tick for an arbitrary configuration
    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter holding 0..n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pmod_debounce.sv
// Purpose: one PMOD pin: 2-FF synchroniser, tick-driven debounce counter, debounced level.
// Latency: 2 cycles pin->sync, then DEB_TICKS ticks of a stable differing level (3 cycles total without debounce).
// Backpressure: none; free-running, level_nxt is the value level takes on the next edge.
// Ports: clk, rst_n (async active-low), pin (raw async input), tick (shared sample strobe),
//        level (debounced state), level_nxt (combinational next state, for change detection).
// Build option: PMOD_READER_DEBOUNCE_EN enables the counter; otherwise level follows the synchroniser.
module pmod_debounce
    import pmod_reader_pkg::*;
#(
    parameter int DEB_TICKS = DEF_DEB_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic tick,
    output logic level,
    output logic level_nxt
);

    logic meta;
    logic sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

`ifdef PMOD_READER_DEBOUNCE_EN
    localparam int CW = cnt_width(DEB_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // cnt counts consecutive ticks on which the synchronised pin disagreed with level;
    // any agreeing tick restarts qualification.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = cnt;
        if (tick) begin
            if (sync == level) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                level_nxt = ~level;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    assign level_nxt = sync;

    logic unused_tick;
    assign unused_tick = tick;
    localparam int unused_deb = DEB_TICKS;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
        end else begin
            level <= level_nxt;
        end
    end

endmodule

// File: rtl/pmod_reader.sv
// Purpose: samples WIDTH PMOD pins, debounces them and reports every change of STATE as an event.
// Latency: STATE and event fields update on the same edge; pin->STATE is sync + DEB_TICKS ticks (3 cycles without debounce).
// Backpressure: one-entry event register; while stalled new changes merge into it, a re-change of a pending pin sets EV_OVERFLOW.
// Ports: CLK_100, RST_N (async active-low), PMOD_IN raw pins, STATE debounced levels,
//        EV_VALID/EV_READY/EV_DATA/EV_MASK event port, EV_OVERFLOW sticky loss flag, OVF_CLR clears it.
// Build option: PMOD_READER_DEBOUNCE_EN enables prescaler + debounce; when undefined STATE follows the synchroniser.
module pmod_reader
    import pmod_reader_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int TICK_HZ   = DEF_TICK_HZ,
    parameter int DEB_TICKS = DEF_DEB_TICKS,
    parameter int WIDTH     = DEF_WIDTH
) (
    input  logic             CLK_100,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] PMOD_IN,
    output logic [WIDTH-1:0] STATE,
    output logic             EV_VALID,
    input  logic             EV_READY,
    output logic [WIDTH-1:0] EV_DATA,
    output logic [WIDTH-1:0] EV_MASK,
    output logic             EV_OVERFLOW,
    input  logic             OVF_CLR
);

    logic tick;

`ifdef PMOD_READER_DEBOUNCE_EN
    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end
`else
    assign tick = 1'b0;
    localparam int unused_cfg = CLK_HZ + TICK_HZ;
`endif

    logic [WIDTH-1:0] state_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        pmod_debounce #(
            .DEB_TICKS (DEB_TICKS)
        ) u_deb (
            .clk       (CLK_100),
            .rst_n     (RST_N),
            .pin       (PMOD_IN[i]),
            .tick      (tick),
            .level     (STATE[i]),
            .level_nxt (state_nxt[i])
        );
    end

    // All pins update on the same tick, so simultaneous changes share one change vector.
    logic [WIDTH-1:0] ch;
    logic             stall;

    assign ch    = state_nxt ^ STATE;
    assign stall = EV_VALID & ~EV_READY;

    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            EV_VALID <= 1'b0;
            EV_DATA  <= '0;
            EV_MASK  <= '0;
        end else if (ch != '0) begin
            // Accept and reload in the same cycle when the consumer is ready.
            EV_VALID <= 1'b1;
            EV_DATA  <= state_nxt;
            EV_MASK  <= stall ? (EV_MASK | ch) : ch;
        end else if (EV_VALID && EV_READY) begin
            EV_VALID <= 1'b0;
        end
    end

    // A pending pin changing again before the consumer saw the first change loses a transition.
    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            EV_OVERFLOW <= 1'b0;
        end else if (stall && ((EV_MASK & ch) != '0)) begin
            EV_OVERFLOW <= 1'b1;
        end else if (OVF_CLR) begin
            EV_OVERFLOW <= 1'b0;
        end
    end

endmodule
